// File: rtl/mmio_pkg.sv
// Shared types and address map for the CPU-side MMIO requester and its device block.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] MMIO_BASE_DEF  = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_LIMIT_DEF = 32'hFFFF_FFFF;

  // Device address map inside the MMIO window
  localparam logic [31:0] SW_ADDR   = 32'hFFFF_0000;
  localparam logic [31:0] LED_ADDR  = 32'hFFFF_0080;
  localparam logic [31:0] SEG7_ADDR = 32'hFFFF_0100;
  localparam logic [31:0] ROM_BASE  = 32'hFFFF_8000;
  localparam logic [31:0] ROM_LAST  = 32'hFFFF_FFFC;

  // Word-aligned and inside [base, limit]; the extra bit keeps an all-ones limit meaningful.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] limit);
    return (addr[1:0] == 2'b00) &&
           ({1'b0, addr} >= {1'b0, base}) &&
           ({1'b0, addr} <= {1'b0, limit});
  endfunction

endpackage

// File: rtl/mmio_bus_master_if.sv
// CPU request/response and MMIO device signals of the bus master, grouped as one bundle.
interface mmio_bus_master_if;

  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mmio_read;
  logic        mmio_write;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_write_data;
  logic        mmio_done;
  logic [31:0] mmio_read_data;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mmio_done, mmio_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mmio_read, mmio_write, mmio_addr, mmio_write_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mmio_done, mmio_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mmio_read, mmio_write, mmio_addr, mmio_write_data
  );

endinterface

// File: rtl/mmio_watchdog.sv
// Saturating cycle counter that flags the last allowed cycle of an MMIO access.
module mmio_watchdog #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the cycles already spent, so this fires on the TIMEOUT_CYCLES-th enabled cycle.
  assign expired = enable && (cnt >= LAST);

endmodule

// File: rtl/mmio_bus_master.sv
// Single-outstanding MMIO requester: alignment/range checks, held strobes, watchdog-bounded access.
module mmio_bus_master
  import mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE      = MMIO_BASE_DEF,
  parameter logic [31:0] MMIO_LIMIT     = MMIO_LIMIT_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                sys_clk,
  input  logic                rst,
  mmio_bus_master_if.master   bus
);

  state_t      state;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        wd_expired;

  mmio_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clear   (state == RESP),
    .enable  (state == ACCESS),
    .expired (wd_expired)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            write_q <= bus.req_write;
            if (addr_ok(bus.req_addr, MMIO_BASE, MMIO_LIMIT)) begin
              state <= ACCESS;
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state   <= RESP;
            end
          end
        end
        ACCESS: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (bus.mmio_done) begin
            rdata_q <= write_q ? '0 : bus.mmio_read_data;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (wd_expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them immediately.
  assign bus.mmio_read       = (state == ACCESS) && !write_q;
  assign bus.mmio_write      = (state == ACCESS) &&  write_q;
  assign bus.mmio_addr       = addr_q;
  assign bus.mmio_write_data = wdata_q;
  assign bus.req_ready       = (state == IDLE);
  assign bus.resp_valid      = (state == RESP);
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_err        = err_q;

endmodule

// File: tb/tb_mmio_bus_master.sv
// Bench for mmio_bus_master: directed vector table, reset-in-access sequence, randomized model check.
module tb_mmio_bus_master;
  import mmio_pkg::*;

  localparam int unsigned TO = 255;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  mmio_bus_master_if bus();

  mmio_bus_master #(
    .MMIO_BASE      (MMIO_BASE_DEF),
    .MMIO_LIMIT     (MMIO_LIMIT_DEF),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (8)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  // Device stand-in: done after dev_lat extra strobe cycles; done_noise drives done outside accesses.
  int          dev_lat    = 0;
  logic [31:0] dev_rdata  = '0;
  logic        done_noise = 1'b0;
  int          strobe_cnt;
  logic        strobe;

  assign strobe = bus.mmio_read | bus.mmio_write;
  always @(posedge sys_clk or posedge rst) begin
    if (rst)         strobe_cnt <= 0;
    else if (strobe) strobe_cnt <= strobe_cnt + 1;
    else             strobe_cnt <= 0;
  end
  assign bus.mmio_done      = strobe ? (strobe_cnt == dev_lat) : done_noise;
  assign bus.mmio_read_data = dev_rdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] dd;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_n;
    int          exp_strobes;
  } vec_t;

  vec_t vecs[11];

  // Expected outcome from the rules alone: bad address -> error next cycle; else the access
  // lasts lat+1 cycles capped at TO, and running into the cap means a timeout error.
  task automatic model(input logic wr, input logic [31:0] a, input int lat, input logic [31:0] dd,
                       output logic e_err, output logic [31:0] e_rdata,
                       output int e_n, output int e_strobes);
    int cycles;
    bit bad;
    bad = (a % 4 != 0) || (longint'(a) < longint'(MMIO_BASE_DEF)) ||
          (longint'(a) > longint'(MMIO_LIMIT_DEF));
    if (bad) begin
      e_err = 1'b1; e_rdata = '0; e_n = 1; e_strobes = 0;
    end else begin
      cycles    = (lat + 1 < int'(TO)) ? lat + 1 : int'(TO);
      e_err     = (lat + 1 > int'(TO));
      e_rdata   = (e_err || wr) ? 32'h0 : dd;
      e_n       = cycles + 1;
      e_strobes = cycles;
    end
  endtask

  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input logic [31:0] dd,
                         output logic [31:0] g_rdata, output logic g_err,
                         output int g_n, output int g_strobes);
    int bad;
    bad = 0; g_n = 0; g_strobes = 0; g_rdata = '0; g_err = 1'b0;
    @(negedge sys_clk);
    chk("ready_before_req", 32'(bus.req_ready), 32'd1);
    dev_lat = lat; dev_rdata = dd; done_noise = 1'($urandom_range(0, 1));
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
    @(posedge sys_clk); #1;
    bus.req_valid = 1'b0; bus.req_addr = $urandom(); bus.req_wdata = $urandom();
    for (int n = 1; n <= 400; n++) begin
      @(negedge sys_clk);
      if (bus.resp_valid) begin
        g_n = n; g_rdata = bus.resp_rdata; g_err = bus.resp_err;
        if (strobe) bad++;
        break;
      end
      if (strobe) begin
        g_strobes++;
        if (bus.mmio_write !== wr || bus.mmio_read !== !wr || bus.mmio_addr !== a ||
            (wr && bus.mmio_write_data !== d)) bad++;
      end
      if (bus.req_ready) bad++;
    end
    chk("strobe_hold_bad_cycles", 32'(bad), 32'd0);
    @(negedge sys_clk);
    chk("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
    chk("resp_rdata_held", bus.resp_rdata, g_rdata);
    chk("ready_after_resp", 32'(bus.req_ready), 32'd1);
    chk("no_strobe_idle", 32'(strobe), 32'd0);
  endtask

  task automatic check_result(input string tag, input vec_t v);
    logic [31:0] g_rdata;
    logic        g_err;
    int          g_n, g_s;
    run_txn(v.wr, v.addr, v.wdata, v.lat, v.dd, g_rdata, g_err, g_n, g_s);
    chk({tag, " err"},     32'(g_err),  32'(v.exp_err));
    chk({tag, " rdata"},   g_rdata,     v.exp_rdata);
    chk({tag, " latency"}, 32'(g_n),    32'(v.exp_n));
    chk({tag, " strobes"}, 32'(g_s),    32'(v.exp_strobes));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    //            wr    addr           wdata          lat   dd             err   rdata          n    strobes
    vecs[0]  = '{1'b0, SW_ADDR,       32'h0,         0,    32'h00A5A5A5,  1'b0, 32'h00A5A5A5,  2,   1};
    vecs[1]  = '{1'b1, LED_ADDR,      32'h0000FFFF,  3,    32'hDEADBEEF,  1'b0, 32'h0,         5,   4};
    vecs[2]  = '{1'b0, 32'hFFFF0002,  32'h0,         0,    32'h11111111,  1'b1, 32'h0,         1,   0};
    vecs[3]  = '{1'b0, 32'h00001000,  32'h0,         0,    32'h22222222,  1'b1, 32'h0,         1,   0};
    vecs[4]  = '{1'b0, 32'hFFFF0200,  32'h0,         1000, 32'h00000055,  1'b1, 32'h0,         256, 255};
    vecs[5]  = '{1'b0, 32'hFFFF0204,  32'h0,         254,  32'h12345678,  1'b0, 32'h12345678,  256, 255};
    vecs[6]  = '{1'b0, SEG7_ADDR,     32'h0,         253,  32'hCAFE0001,  1'b0, 32'hCAFE0001,  255, 254};
    vecs[7]  = '{1'b1, ROM_LAST,      32'h00000001,  1,    32'h33333333,  1'b0, 32'h0,         3,   2};
    vecs[8]  = '{1'b0, 32'hFFFEFFFC,  32'h0,         0,    32'h44444444,  1'b1, 32'h0,         1,   0};
    vecs[9]  = '{1'b1, 32'hFFFF0001,  32'h5,         0,    32'h0,         1'b1, 32'h0,         1,   0};
    vecs[10] = '{1'b0, ROM_BASE,      32'h0,         255,  32'h00000009,  1'b1, 32'h0,         256, 255};

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst mmio_read",  32'(bus.mmio_read),  32'd0);
    chk("rst mmio_write", 32'(bus.mmio_write), 32'd0);
    chk("rst mmio_addr",  bus.mmio_addr,       32'd0);
    chk("rst mmio_wdata", bus.mmio_write_data, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) check_result($sformatf("vec%0d", i), vecs[i]);

    // Reset while a silent device holds the access open
    @(negedge sys_clk);
    dev_lat = 1000;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'hFFFF0300;
    @(posedge sys_clk); #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    chk("pre_rst mmio_read", 32'(bus.mmio_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst mmio_read",  32'(bus.mmio_read),  32'd0);
    chk("mid_rst mmio_write", 32'(bus.mmio_write), 32'd0);
    chk("mid_rst req_ready",  32'(bus.req_ready),  32'd1);
    chk("mid_rst resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    rv = '{1'b0, SW_ADDR, 32'h0, 2, 32'h00000077, 1'b0, 32'h00000077, 4, 3};
    check_result("after_rst", rv);

    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      rv.wr    = 1'($urandom_range(0, 1));
      rv.wdata = $urandom();
      rv.dd    = $urandom();
      case (sel)
        0:       rv.addr = MMIO_BASE_DEF + ($urandom_range(0, 16383) << 2);
        1:       rv.addr = MMIO_BASE_DEF + ($urandom_range(0, 16383) << 2) + $urandom_range(1, 3);
        2:       rv.addr = $urandom_range(0, 32'hFFFE_FFFF);
        default: rv.addr = ROM_LAST - ($urandom_range(0, 63) << 2);
      endcase
      rv.lat = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(0, 6));
      model(rv.wr, rv.addr, rv.lat, rv.dd, rv.exp_err, rv.exp_rdata, rv.exp_n, rv.exp_strobes);
      check_result($sformatf("rnd%0d", i), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
